// File: rtl/fetch_latch_pkg.sv
// Shared types for the instruction-fetch stage: state encoding,
// the IF/ID register layout and the default NOP word.
package fetch_latch_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t NOP = 32'h0000_0000;

  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t pc;
    word_t npc;
  } ifid_t;

  // Sequential PC; wraps naturally at the top of the 32-bit space.
  function automatic word_t next_pc(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_latch.sv
// Instruction-fetch stage: issues imem reads at the current PC, gates the
// PC stage, and loads the IF/ID register. A one-entry hold buffer parks a
// fetched instruction while decode is stalled.
//
// state  | meaning
// FETCH  | reading imem at pcout; loads IF/ID or parks into hold buffer
// HOLD   | instruction parked, waiting for decode to release the stall
// HALTED | halt seen; no fetches, no PC updates until reset
module fetch_latch
  import fetch_latch_pkg::*;
#(
  parameter word_t NOP_INSTR = NOP
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pcout,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        id_stall,
  input  logic        flush,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic        pcenable,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_npc
);

  fetch_state_t state;
  ifid_t        ifid;
  ifid_t        hold;

  // Memory request and PC-advance enable; forced quiet in reset and halt.
  always_comb begin
    imemaddr = pcout;
    imemREN  = 1'b0;
    pcenable = 1'b0;
    if (!RST && state != HALTED && !halt) begin
      imemREN = (state == FETCH);
      if (flush)
        pcenable = 1'b1;          // let the PC stage take the redirect target
      else if (state == FETCH)
        pcenable = ihit;
    end
  end

  // Fetch FSM with IF/ID register and hold buffer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= FETCH;
      ifid  <= '{valid: 1'b0, instr: NOP_INSTR, pc: '0, npc: '0};
      hold  <= '{valid: 1'b0, instr: NOP_INSTR, pc: '0, npc: '0};
    end else if (state == HALTED) begin
      state <= HALTED;
    end else if (halt) begin
      state       <= HALTED;
      ifid.valid  <= 1'b0;
      ifid.instr  <= NOP_INSTR;
      hold.valid  <= 1'b0;
    end else if (flush) begin
      // Any same-cycle ihit and any parked instruction are discarded.
      state      <= FETCH;
      ifid       <= '{valid: 1'b0, instr: NOP_INSTR, pc: '0, npc: '0};
      hold.valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (ihit && !id_stall) begin
            ifid <= '{valid: 1'b1, instr: imemload, pc: pcout, npc: next_pc(pcout)};
          end else if (ihit && id_stall) begin
            hold  <= '{valid: 1'b1, instr: imemload, pc: pcout, npc: next_pc(pcout)};
            state <= HOLD;
          end else if (!id_stall) begin
            ifid.valid <= 1'b0;
            ifid.instr <= NOP_INSTR;
          end
        end
        HOLD: begin
          if (!id_stall) begin
            ifid       <= hold;
            hold.valid <= 1'b0;
            state      <= FETCH;
          end
        end
        default: state <= HALTED;
      endcase
    end
  end

  assign if_valid = ifid.valid;
  assign if_instr = ifid.instr;
  assign if_pc    = ifid.pc;
  assign if_npc   = ifid.npc;

endmodule
